// File: rtl/alu_regfile_pipe.sv
// Two-stage ALU + register-file datapath: issue/execute on one edge, writeback on the next,
// with WB-to-issue forwarding so dependent ops can run back to back.
module alu_regfile_pipe #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH),
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             op_valid,
  input  logic [2:0]       opcode,
  input  logic [AW-1:0]    src_a,
  input  logic [AW-1:0]    src_b,
  input  logic             use_imm,
  input  logic [WIDTH-1:0] imm,
  input  logic [AW-1:0]    dst,
  input  logic [AW-1:0]    read_addr,
  output logic [WIDTH-1:0] read_data,
  output logic [WIDTH-1:0] result,
  output logic             result_valid,
  output logic             carry,
  output logic             zero,
  output logic [CNT_W-1:0] op_count
);

  typedef enum logic [2:0] {
    OP_AND  = 3'b000,
    OP_OR   = 3'b001,
    OP_NAND = 3'b010,
    OP_NOR  = 3'b011,
    OP_ADD  = 3'b100,
    OP_SUB  = 3'b101,
    OP_XOR  = 3'b110,
    OP_PASS = 3'b111
  } opcode_e;

  logic [WIDTH-1:0] regs_q [DEPTH];
  logic [WIDTH-1:0] regs_d [DEPTH];
  logic [WIDTH-1:0] result_q, result_d;
  logic             carry_q, carry_d;
  logic             zero_q, zero_d;
  logic             wb_valid_q, wb_valid_d;
  logic [AW-1:0]    wb_dst_q, wb_dst_d;
  logic [CNT_W-1:0] op_count_q, op_count_d;

  logic [WIDTH-1:0] opnd_a, opnd_b;
  logic [WIDTH:0]   sum_ext, diff_ext;

  // The WB stage's pending value is result_q itself, since result holds until the next valid op.
  always_comb begin
    opnd_a = regs_q[src_a];
    if (wb_valid_q && (wb_dst_q == src_a)) opnd_a = result_q;
    opnd_b = regs_q[src_b];
    if (wb_valid_q && (wb_dst_q == src_b)) opnd_b = result_q;
    if (use_imm) opnd_b = imm;
  end

  assign sum_ext  = {1'b0, opnd_a} + {1'b0, opnd_b};
  assign diff_ext = {1'b0, opnd_a} - {1'b0, opnd_b};

  always_comb begin
    result_d   = result_q;
    carry_d    = carry_q;
    zero_d     = zero_q;
    wb_valid_d = op_valid;
    wb_dst_d   = wb_dst_q;
    if (op_valid) begin
      wb_dst_d = dst;
      carry_d  = 1'b0;
      unique case (opcode_e'(opcode))
        OP_AND:  result_d = opnd_a & opnd_b;
        OP_OR:   result_d = opnd_a | opnd_b;
        OP_NAND: result_d = ~(opnd_a & opnd_b);
        OP_NOR:  result_d = ~(opnd_a | opnd_b);
        OP_ADD: begin
          result_d = sum_ext[WIDTH-1:0];
          carry_d  = sum_ext[WIDTH];
        end
        OP_SUB: begin
          result_d = diff_ext[WIDTH-1:0];
          carry_d  = diff_ext[WIDTH];
        end
        OP_XOR:  result_d = opnd_a ^ opnd_b;
        OP_PASS: result_d = opnd_b;
        default: result_d = opnd_b;
      endcase
      zero_d = (result_d == '0);
    end
  end

  always_comb begin
    regs_d     = regs_q;
    op_count_d = op_count_q;
    if (wb_valid_q) begin
      regs_d[wb_dst_q] = result_q;
      op_count_d       = op_count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
      result_q   <= '0;
      carry_q    <= 1'b0;
      zero_q     <= 1'b0;
      wb_valid_q <= 1'b0;
      wb_dst_q   <= '0;
      op_count_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= regs_d[i];
      result_q   <= result_d;
      carry_q    <= carry_d;
      zero_q     <= zero_d;
      wb_valid_q <= wb_valid_d;
      wb_dst_q   <= wb_dst_d;
      op_count_q <= op_count_d;
    end
  end

  assign read_data    = regs_q[read_addr];
  assign result       = result_q;
  assign result_valid = wb_valid_q;
  assign carry        = carry_q;
  assign zero         = zero_q;
  assign op_count     = op_count_q;

endmodule
